// File: rtl/vga_pkg.sv
// Timing constants for 640x480@60 and the derived sync window positions.
// Also provides the inclusive range compare used by the sync decodes.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam bit          SYNC_POL = 1'b0;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  function automatic logic in_range(input logic [9:0] val,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/axis_counter.sv
// Modulo-N position counter with enable; o_wrap flags the terminal count so
// the next enabled cycle returns to zero.
module axis_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt  = cnt_q;
  assign o_wrap = (cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Pixel timing generator: h/v position counters stepped by the pixel strobe,
// with sync, blanking, clamped coordinates, frame markers and frame counter.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter bit          SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_blanking,
  output logic        o_active,
  output logic        o_screenend,
  output logic        o_animate,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic [15:0] o_frame
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_W = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_W = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_MAX   = 9'(V_ACTIVE - 1);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        h_wrap;
  logic        v_wrap;
  logic        v_en;
  logic [15:0] frame_q;
  logic [15:0] frame_d;
  logic        h_vis;
  logic        v_vis;

  assign v_en = i_pix_stb & h_wrap;

  axis_counter #(.N(H_TOT), .W(10)) u_h_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_pix_stb),
    .o_cnt  (h_cnt),
    .o_wrap (h_wrap)
  );

  axis_counter #(.N(V_TOT), .W(10)) u_v_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (v_en),
    .o_cnt  (v_cnt),
    .o_wrap (v_wrap)
  );

  always_comb begin
    frame_d = frame_q;
    if (v_en && v_wrap) begin
      frame_d = frame_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) frame_q <= '0;
    else       frame_q <= frame_d;
  end

  // All outputs decode the registered counters directly, so reset reaches
  // them without waiting for a clock edge.
  always_comb begin
    h_vis       = (h_cnt < H_ACT_W);
    v_vis       = (v_cnt < V_ACT_W);
    o_hs        = in_range(h_cnt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
    o_vs        = in_range(v_cnt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
    o_active    = h_vis && v_vis;
    o_blanking  = ~o_active;
    o_x         = h_vis ? h_cnt : X_MAX;
    o_y         = v_vis ? v_cnt[8:0] : Y_MAX;
    o_animate   = (v_cnt == V_ACT_W) && (h_cnt == 10'd0);
    o_screenend = h_wrap && v_wrap;
    o_frame     = frame_q;
  end

endmodule
